// File: rtl/heater_status_pio_pkg.sv
// Shared SoC peripheral definitions: PIO register map and edge-capture modes.
package heater_status_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_EITHER  = 2'd2
  } edge_mode_e;

  // True when the transition prev -> cur matches the selected edge mode.
  function automatic logic edge_hit(input edge_mode_e mode, input logic cur, input logic prev);
    case (mode)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      EDGE_EITHER:  return cur ^ prev;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/heater_status_pio_in_filter.sv
// Per-channel input conditioning: synchroniser chain followed by a debounce filter.
module pio_in_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bypass_i,
  input  logic in_i,
  output logic sync_o,
  output logic stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sync_w;

  assign sync_w   = sync_q[SYNC_STAGES-1];
  assign sync_o   = sync_w;
  assign stable_o = stable_q;

  // Metastability chain for the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Accept a new level once it has differed from stable for the required run;
  // the load happens on the edge the run counter would reach the threshold.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (bypass_i) begin
      stable_d = sync_w;
    end else if (sync_w != stable_q) begin
      if (DEBOUNCE_CYCLES <= 1 || cnt_q == CNT_LAST) stable_d = sync_w;
      else                                            cnt_d    = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/heater_status_pio.sv
// Heater status PIO: filtered inputs, edge capture with W1C, IRQ mask, Avalon-MM slave.
module heater_status_pio
  import heater_status_pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_mode_e   MODE     = edge_mode_e'(2'(EDGE_MODE));
  localparam logic [2:0]   INIT_LEN = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_w, stable_w, edge_w, w1c_w;
  logic [WIDTH-1:0] prev_q, prev_d, mask_q, mask_d, cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic [2:0]       init_cnt_q, init_cnt_d;
  logic             init_active, wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_in_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .bypass_i(init_active),
      .in_i    (in_port[i]),
      .sync_o  (sync_w[i]),
      .stable_o(stable_w[i])
    );
  end

  assign init_active = (init_cnt_q != INIT_LEN);
  assign wr_en       = chipselect & ~write_n;

  // Post-reset window: filters track sync directly and edge capture is held off.
  always_comb begin
    init_cnt_d = init_cnt_q;
    if (init_active) init_cnt_d = init_cnt_q + 3'd1;
  end

  // Edge detection against the delayed copy; suppressed while initialising.
  always_comb begin
    edge_w = '0;
    prev_d = init_active ? sync_w : stable_w;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      edge_w[i] = edge_hit(MODE, stable_w[i], prev_q[i]) & ~init_active;
    end
  end

  // Register file next state: mask write, W1C with set priority, read mux, irq.
  always_comb begin
    mask_d = mask_q;
    w1c_w  = '0;
    if (wr_en && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) w1c_w  = writedata[WIDTH-1:0];
    cap_d = (cap_q & ~w1c_w) | edge_w;
    case (address)
      ADDR_DATA:    rdata_d = zext(stable_w);
      ADDR_RSVD:    rdata_d = '0;
      ADDR_IRQMASK: rdata_d = zext(mask_q);
      ADDR_EDGECAP: rdata_d = zext(cap_q);
      default:      rdata_d = '0;
    endcase
    irq_d = |(cap_q & mask_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      init_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule
